// File: rtl/fir_decim_out.sv
// Integrate-and-dump decimator for the FIR output: sums DECIM samples, shifts, saturates, queues in a small FIFO.
// Optional round-half-up scaling is enabled by defining FIR_DECIM_ROUND_EN (truncation toward -inf otherwise).
module fir_decim_out #(
   parameter int WIDTH_IN  = 12,
   parameter int DECIM     = 4,
   parameter int SHIFT     = 2,
   parameter int WIDTH_OUT = 10,
   parameter int DEPTH     = 4
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic signed [WIDTH_IN-1:0]  y,
   input  logic                        y_valid,
   output logic signed [WIDTH_OUT-1:0] m_data,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic                        sat_flag,
   output logic                        drop_flag
);

   localparam int ACC_W = WIDTH_IN + $clog2(DECIM);
   localparam int CNT_W = $clog2(DECIM);
   localparam int PTR_W = $clog2(DEPTH);

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DECIM - 1);
   localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W+1)'(DEPTH);

   // Clamp bounds and rounding constant live at ACC_W+1 bits so the rounding add cannot wrap.
   localparam logic signed [ACC_W:0] OUT_MAX =
      {{(ACC_W + 2 - WIDTH_OUT){1'b0}}, {(WIDTH_OUT - 1){1'b1}}};
   localparam logic signed [ACC_W:0] OUT_MIN = ~OUT_MAX;
   localparam logic [ACC_W:0]        ONE_EXT = (ACC_W+1)'(1);
   localparam logic [ACC_W:0]        RND_K   = (ONE_EXT << SHIFT) >> 1;

   logic signed [ACC_W-1:0]     acc;
   logic        [CNT_W-1:0]     cnt;
   logic signed [ACC_W-1:0]     y_ext;
   logic signed [ACC_W-1:0]     sum;
   logic signed [ACC_W:0]       sum_ext;
   logic signed [ACC_W:0]       scaled;
   logic signed [ACC_W:0]       sat_val;
   logic signed [WIDTH_OUT-1:0] result;
   logic                        clip_hi;
   logic                        clip_lo;
   logic                        dump;

   always_comb begin
      y_ext   = {{(ACC_W - WIDTH_IN){y[WIDTH_IN-1]}}, y};
      sum     = acc + y_ext;
`ifdef FIR_DECIM_ROUND_EN
      sum_ext = {sum[ACC_W-1], sum} + $signed(RND_K);
`else
      sum_ext = {sum[ACC_W-1], sum};
`endif
      scaled  = sum_ext >>> SHIFT;
      clip_hi = scaled > OUT_MAX;
      clip_lo = scaled < OUT_MIN;
      if (clip_hi) begin
         sat_val = OUT_MAX;
      end else if (clip_lo) begin
         sat_val = OUT_MIN;
      end else begin
         sat_val = scaled;
      end
      result = WIDTH_OUT'(sat_val);
      dump   = y_valid && (cnt == CNT_LAST);
   end

   // Bubbles hold both counter and accumulator; the dump edge restarts the block with no gap.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         acc <= '0;
         cnt <= '0;
      end else if (y_valid) begin
         if (dump) begin
            acc <= '0;
            cnt <= '0;
         end else begin
            acc <= sum;
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   // Output handshake: a transfer happens on every clk edge where m_valid && m_ready;
   // m_data is the FIFO head and stays constant until that transfer; m_ready is ignored while m_valid=0.
   logic signed [WIDTH_OUT-1:0] mem [DEPTH];
   logic [PTR_W-1:0]            wr_ptr;
   logic [PTR_W-1:0]            rd_ptr;
   logic [PTR_W:0]              count;
   logic                        full;
   logic                        pop;
   logic                        push;
   logic                        drop;

   always_comb begin
      full = (count == FIFO_FULL);
      pop  = m_valid && m_ready;
      push = dump && (!full || pop);
      drop = dump && full && !pop;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         sat_flag  <= 1'b0;
         drop_flag <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr] <= result;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
         // Clipping is reported even when the clipped result is then dropped.
         if (dump && (clip_hi || clip_lo)) begin
            sat_flag <= 1'b1;
         end
         if (drop) begin
            drop_flag <= 1'b1;
         end
      end
   end

   assign m_valid = (count != '0);
   assign m_data  = mem[rd_ptr];

endmodule

// File: tb/tb_fir_decim_out.sv
// Bench for fir_decim_out: scenario tasks plus a scoreboard that checks every handshaked output word in order.
module tb_fir_decim_out;

   localparam int WIDTH_IN  = 12;
   localparam int DECIM     = 4;
   localparam int SHIFT     = 2;
   localparam int WIDTH_OUT = 10;
   localparam int DEPTH     = 4;

   logic                        clk = 1'b0;
   logic                        rstn;
   logic signed [WIDTH_IN-1:0]  y;
   logic                        y_valid;
   logic signed [WIDTH_OUT-1:0] m_data;
   logic                        m_valid;
   logic                        m_ready;
   logic                        sat_flag;
   logic                        drop_flag;

   int checks   = 0;
   int failures = 0;

   logic [WIDTH_OUT-1:0] exp_q[$];
   logic [WIDTH_OUT-1:0] exp_v;

   always #5 clk = ~clk;

   fir_decim_out #(
      .WIDTH_IN (WIDTH_IN),
      .DECIM    (DECIM),
      .SHIFT    (SHIFT),
      .WIDTH_OUT(WIDTH_OUT),
      .DEPTH    (DEPTH)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .y        (y),
      .y_valid  (y_valid),
      .m_data   (m_data),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .sat_flag (sat_flag),
      .drop_flag(drop_flag)
   );

   // Reference: block sum -> shift (optionally round-half-up) -> clamp.
   function automatic int model_result(input int s);
      int r;
      int hi;
      int lo;
`ifdef FIR_DECIM_ROUND_EN
      r = (s + ((1 << SHIFT) >> 1)) >>> SHIFT;
`else
      r = s >>> SHIFT;
`endif
      hi = (1 << (WIDTH_OUT - 1)) - 1;
      lo = -(1 << (WIDTH_OUT - 1));
      if (r > hi) r = hi;
      if (r < lo) r = lo;
      return r;
   endfunction

   // Scoreboard: every accepted output word is checked against the head of exp_q.
   always @(negedge clk) begin
      if (rstn === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL pop_unexpected: got m_data=%0d, required no output", m_data);
         end else begin
            exp_v = exp_q.pop_front();
            if (m_data !== exp_v) begin
               failures++;
               $display("FAIL pop_data: got m_data=%0d, required %0d", m_data, $signed(exp_v));
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input int v, input bit vld);
      y       = WIDTH_IN'(v);
      y_valid = vld;
      @(posedge clk);
      #1;
      y_valid = 1'b0;
   endtask

   task automatic send_block(input int v);
      for (int i = 0; i < DECIM; i++) send(v, 1'b1);
   endtask

   task automatic do_reset();
      rstn    = 1'b0;
      y_valid = 1'b0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
      exp_q.delete();
   endtask

   task automatic drain();
      m_ready = 1'b1;
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rstn    = 1'b0;
      y_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks += 4;
      if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid: got %b, required 0", m_valid); end
      if (m_data !== 10'(0)) begin failures++; $display("FAIL reset_m_data: got %0d, required 0", m_data); end
      if (sat_flag !== 1'b0) begin failures++; $display("FAIL reset_sat_flag: got %b, required 0", sat_flag); end
      if (drop_flag !== 1'b0) begin failures++; $display("FAIL reset_drop_flag: got %b, required 0", drop_flag); end
      rstn = 1'b1;
   endtask

   task automatic test_basic();
      m_ready = 1'b1;
      send(10, 1'b1);
      send(20, 1'b1);
      send(30, 1'b1);
      checks++;
      if (m_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid: got %b, required 0", m_valid); end
      exp_q.push_back(WIDTH_OUT'(model_result(100)));
      send(40, 1'b1);
      checks += 2;
      if (m_valid !== 1'b1) begin failures++; $display("FAIL basic_latency: got m_valid=%b, required 1", m_valid); end
      if (m_data !== 10'(25)) begin failures++; $display("FAIL basic_data: got %0d, required 25", m_data); end
      repeat (4) begin @(posedge clk); #1; end
      checks += 2;
      if (m_valid !== 1'b0) begin failures++; $display("FAIL basic_idle_valid: got %b, required 0", m_valid); end
      if (exp_q.size() != 0) begin failures++; $display("FAIL basic_left: got %0d queued, required 0", exp_q.size()); end
   endtask

   task automatic test_rounding();
      int e_pos;
      int e_neg;
`ifdef FIR_DECIM_ROUND_EN
      e_pos = 2;
      e_neg = -1;
`else
      e_pos = 1;
      e_neg = -2;
`endif
      do_reset();
      send(1, 1'b1); send(1, 1'b1); send(1, 1'b1);
      exp_q.push_back(WIDTH_OUT'(model_result(6)));
      send(3, 1'b1);
      checks++;
      if (m_data !== WIDTH_OUT'(e_pos)) begin failures++; $display("FAIL round_pos: got %0d, required %0d", m_data, e_pos); end
      drain();
      send(-1, 1'b1); send(-1, 1'b1); send(-1, 1'b1);
      exp_q.push_back(WIDTH_OUT'(model_result(-6)));
      send(-3, 1'b1);
      checks++;
      if (m_data !== WIDTH_OUT'(e_neg)) begin failures++; $display("FAIL round_neg: got %0d, required %0d", m_data, e_neg); end
      drain();
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL round_left: got %0d queued, required 0", exp_q.size()); end
   endtask

   task automatic test_saturation();
      do_reset();
      exp_q.push_back(WIDTH_OUT'(model_result(4 * 2047)));
      send_block(2047);
      checks += 2;
      if (m_data !== 10'(511)) begin failures++; $display("FAIL sat_pos_data: got %0d, required 511", m_data); end
      if (sat_flag !== 1'b1) begin failures++; $display("FAIL sat_pos_flag: got %b, required 1", sat_flag); end
      drain();
      do_reset();
      checks++;
      if (sat_flag !== 1'b0) begin failures++; $display("FAIL sat_flag_reset: got %b, required 0", sat_flag); end
      exp_q.push_back(WIDTH_OUT'(model_result(4 * -2048)));
      send_block(-2048);
      checks += 2;
      if (m_data !== 10'(-512)) begin failures++; $display("FAIL sat_neg_data: got %0d, required -512", m_data); end
      if (sat_flag !== 1'b1) begin failures++; $display("FAIL sat_neg_flag: got %b, required 1", sat_flag); end
      drain();
      do_reset();
      exp_q.push_back(WIDTH_OUT'(model_result(400)));
      send_block(100);
      checks += 2;
      if (m_data !== 10'(100)) begin failures++; $display("FAIL nosat_data: got %0d, required 100", m_data); end
      if (sat_flag !== 1'b0) begin failures++; $display("FAIL nosat_flag: got %b, required 0", sat_flag); end
      drain();
   endtask

   task automatic test_backpressure();
      do_reset();
      m_ready = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         if (k <= DEPTH) exp_q.push_back(WIDTH_OUT'(model_result(DECIM * 4 * k)));
         send_block(4 * k);
      end
      repeat (2) begin @(posedge clk); #1; end
      checks += 3;
      if (drop_flag !== 1'b1) begin failures++; $display("FAIL bp_drop_flag: got %b, required 1", drop_flag); end
      if (m_valid !== 1'b1) begin failures++; $display("FAIL bp_valid: got %b, required 1", m_valid); end
      if (m_data !== 10'(4)) begin failures++; $display("FAIL bp_hold: got %0d, required 4", m_data); end
      m_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         checks++;
         if (m_valid !== 1'b1) begin failures++; $display("FAIL bp_drain_valid: cycle %0d got %b, required 1", i, m_valid); end
         @(posedge clk);
         #1;
      end
      checks += 2;
      if (m_valid !== 1'b0) begin failures++; $display("FAIL bp_empty: got m_valid=%b, required 0", m_valid); end
      if (exp_q.size() != 0) begin failures++; $display("FAIL bp_left: got %0d queued, required 0", exp_q.size()); end
   endtask

   task automatic test_full_no_drop();
      do_reset();
      m_ready = 1'b0;
      for (int k = 1; k <= DEPTH; k++) begin
         exp_q.push_back(WIDTH_OUT'(model_result(DECIM * 4 * k)));
         send_block(4 * k);
      end
      for (int i = 0; i < DECIM - 1; i++) send(20, 1'b1);
      exp_q.push_back(WIDTH_OUT'(model_result(DECIM * 20)));
      m_ready = 1'b1;
      send(20, 1'b1);
      checks++;
      if (drop_flag !== 1'b0) begin failures++; $display("FAIL full_pop_drop: got %b, required 0", drop_flag); end
      drain();
      @(posedge clk);
      #1;
      checks += 2;
      if (exp_q.size() != 0) begin failures++; $display("FAIL full_left: got %0d queued, required 0", exp_q.size()); end
      if (m_valid !== 1'b0) begin failures++; $display("FAIL full_empty: got m_valid=%b, required 0", m_valid); end
   endtask

   task automatic test_bubbles();
      bit pat [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      do_reset();
      m_ready = 1'b1;
      exp_q.push_back(WIDTH_OUT'(model_result(20)));
      for (int i = 0; i < 7; i++) begin
         send(5, pat[i]);
         checks++;
         if (i < 6) begin
            if (m_valid !== 1'b0) begin failures++; $display("FAIL bubble_early: step %0d got m_valid=%b, required 0", i, m_valid); end
         end else begin
            if (m_valid !== 1'b1 || m_data !== 10'(5)) begin
               failures++;
               $display("FAIL bubble_result: got m_valid=%b m_data=%0d, required 1 and 5", m_valid, m_data);
            end
         end
      end
      repeat (3) begin @(posedge clk); #1; end
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL bubble_left: got %0d queued, required 0", exp_q.size()); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      m_ready = 1'b0;
      send_block(2047);
      send(50, 1'b1);
      send(50, 1'b1);
      checks++;
      if (sat_flag !== 1'b1 || m_valid !== 1'b1) begin
         failures++;
         $display("FAIL mid_pre: got sat_flag=%b m_valid=%b, required 1 and 1", sat_flag, m_valid);
      end
      do_reset();
      checks += 4;
      if (m_valid !== 1'b0) begin failures++; $display("FAIL mid_valid: got %b, required 0", m_valid); end
      if (m_data !== 10'(0)) begin failures++; $display("FAIL mid_data: got %0d, required 0", m_data); end
      if (sat_flag !== 1'b0) begin failures++; $display("FAIL mid_sat: got %b, required 0", sat_flag); end
      if (drop_flag !== 1'b0) begin failures++; $display("FAIL mid_drop: got %b, required 0", drop_flag); end
      m_ready = 1'b1;
      exp_q.push_back(WIDTH_OUT'(model_result(32)));
      send_block(8);
      checks++;
      if (m_data !== 10'(8)) begin failures++; $display("FAIL mid_next: got %0d, required 8", m_data); end
      drain();
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL mid_left: got %0d queued, required 0", exp_q.size()); end
   endtask

   initial begin
      rstn    = 1'b0;
      y       = '0;
      y_valid = 1'b0;
      m_ready = 1'b1;
      test_reset();
      test_basic();
      test_rounding();
      test_saturation();
      test_backpressure();
      test_full_no_drop();
      test_bubbles();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
